sd_event_sync: RTL and testbench



---
 rtl/sd_event_sync_pkg.sv | 19 +
 rtl/sd_event_sync_chan.sv | 87 ++++++++
 rtl/sd_event_sync.sv | 79 +++++++
 tb/tb_sd_event_sync.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_event_sync_pkg.sv
// Shared definitions for sd_event_sync: counter saturation limit, counter action
// encoding and the round-robin successor used by sdlib arbiters.
package sd_event_sync_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    function automatic int unsigned CNT_MAX(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/sd_event_sync_chan.sv
// One event channel: toggle synchronizer, edge detect and saturating pending count.
// Optional sticky overflow flag when SD_EVENT_SYNC_OVF_EN is defined.
module sd_event_sync_chan
    import sd_event_sync_pkg::*;
#(
    parameter int sync_stages = 2,
    parameter int cnt_w       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tgl,
    input  logic i_dec,
    output logic o_pulse,
    output logic o_nz
`ifdef SD_EVENT_SYNC_OVF_EN
    ,
    output logic o_ovf
`endif
);

    localparam logic [cnt_w-1:0] LP_CNT_MAX = cnt_w'(CNT_MAX(cnt_w));

    logic [sync_stages-1:0] r_sync;
    logic                   r_pulse;
    logic [cnt_w-1:0]       r_cnt;
    cnt_op_e                w_op;
    logic                   w_drop;

    // NOTE: the synchronizer chain has no reset; it must keep following tgl_in
    // during reset so the edge detector is settled by the time reset releases.
    always_ff @(posedge clk) begin
        r_sync <= {r_sync[sync_stages-2:0], i_tgl};
    end

    // r_pulse is s[last] ^ d (d = previous s[last]) computed one edge early, so
    // the strobe comes straight off a flop and is forced low across reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= r_sync[sync_stages-1] ^ r_sync[sync_stages-2];
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_op = CNT_HOLD;
        if (r_pulse && !i_dec) begin
            w_op = CNT_INC;
        end else if (!r_pulse && i_dec) begin
            w_op = CNT_DEC;
        end
    end

    assign w_drop = (w_op == CNT_INC) && (r_cnt == LP_CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case (w_op)
                CNT_INC: if (!w_drop) r_cnt <= r_cnt + cnt_w'(1);
                CNT_DEC: r_cnt <= r_cnt - cnt_w'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef SD_EVENT_SYNC_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`endif

    assign o_pulse = r_pulse;
    assign o_nz    = (r_cnt != '0);

endmodule

// File: rtl/sd_event_sync.sv
// Multi-channel toggle-event synchronizer with round-robin srdy/drdy output.
// Define SD_EVENT_SYNC_OVF_EN to add the sticky per-channel ovf port.
module sd_event_sync
    import sd_event_sync_pkg::*;
#(
    parameter int channels    = 4,
    parameter int sync_stages = 2,
    parameter int cnt_w       = 4,
    parameter int chan_w      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [channels-1:0] tgl_in,
    output logic [channels-1:0] pulse_out,
    output logic                p_srdy,
    input  logic                p_drdy,
    output logic [chan_w-1:0]   p_chan
`ifdef SD_EVENT_SYNC_OVF_EN
    ,
    output logic [channels-1:0] ovf
`endif
);

    logic [channels-1:0] w_nz;
    logic [channels-1:0] w_dec;
    logic [chan_w-1:0]   r_ptr;
    logic [chan_w-1:0]   w_sel;
    logic                w_any;

    for (genvar gi = 0; gi < channels; gi++) begin : g_chan
        assign w_dec[gi] = p_srdy & p_drdy & (p_chan == chan_w'(gi));

        sd_event_sync_chan #(
            .sync_stages (sync_stages),
            .cnt_w       (cnt_w)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .i_tgl   (tgl_in[gi]),
            .i_dec   (w_dec[gi]),
            .o_pulse (pulse_out[gi]),
            .o_nz    (w_nz[gi])
`ifdef SD_EVENT_SYNC_OVF_EN
            ,
            .o_ovf   (ovf[gi])
`endif
        );
    end

    // First pass searches ptr..top, second pass wraps to 0..ptr-1.
    always_comb begin
        w_sel = r_ptr;
        w_any = 1'b0;
        for (int i = 0; i < channels; i++) begin
            if (!w_any && w_nz[i] && (i >= int'(r_ptr))) begin
                w_any = 1'b1;
                w_sel = chan_w'(i);
            end
        end
        for (int i = 0; i < channels; i++) begin
            if (!w_any && w_nz[i]) begin
                w_any = 1'b1;
                w_sel = chan_w'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (p_srdy && p_drdy) begin
            r_ptr <= chan_w'(rr_next(32'(p_chan), 32'(channels)));
        end
    end

    assign p_srdy = w_any;
    assign p_chan = w_sel;

endmodule

// File: tb/tb_sd_event_sync.sv
// Self-checking bench for sd_event_sync (4 channels, 2 sync stages, 4-bit counts).
// Covers ovf as well when built with SD_EVENT_SYNC_OVF_EN.
module tb_sd_event_sync;

    localparam int CH   = 4;
    localparam int SS   = 2;
    localparam int CW   = 4;
    localparam int PW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] tgl_in;
    logic [CH-1:0] pulse_out;
    logic          p_srdy;
    logic          p_drdy;
    logic [PW-1:0] p_chan;
`ifdef SD_EVENT_SYNC_OVF_EN
    logic [CH-1:0] ovf;
`endif

    always #5 clk = ~clk;

    sd_event_sync #(
        .channels    (CH),
        .sync_stages (SS),
        .cnt_w       (CW),
        .chan_w      (PW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tgl_in    (tgl_in),
        .pulse_out (pulse_out),
        .p_srdy    (p_srdy),
        .p_drdy    (p_drdy),
        .p_chan    (p_chan)
`ifdef SD_EVENT_SYNC_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tgl history delay line, integer pending counts, rr pointer.
    int            m_cnt [CH];
    int            m_ptr   = 0;
    logic [CH-1:0] m_pulse = '0;
    logic [CH-1:0] m_ovf   = '0;
    logic [CH-1:0] m_hist [SS+1];
    bit            m_srdy  = 1'b0;
    int            m_chan  = 0;
    bit            started = 1'b0;

    function automatic void m_select();
        m_srdy = 1'b0;
        m_chan = m_ptr;
        for (int k = 0; k < CH; k++) begin
            int idx;
            idx = (m_ptr + k) % CH;
            if (!m_srdy && m_cnt[idx] > 0) begin
                m_srdy = 1'b1;
                m_chan = idx;
            end
        end
    endfunction

    initial begin
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        for (int j = 0; j <= SS; j++) m_hist[j] = '0;
    end

    always @(posedge clk) begin
        bit            xfer;
        int            g;
        int            c;
        logic [CH-1:0] new_pulse;
        xfer = m_srdy && p_drdy;
        g    = m_chan;
        for (int j = SS; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = tgl_in;
        if (reset) begin
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
            m_ptr   = 0;
            m_pulse = '0;
            m_ovf   = '0;
        end else begin
            new_pulse = m_hist[SS-1] ^ m_hist[SS];
            for (int i = 0; i < CH; i++) begin
                c = m_cnt[i] + int'(m_pulse[i]) - ((xfer && g == i) ? 1 : 0);
                if (c > MAXC) begin
                    c = MAXC;
                    m_ovf[i] = 1'b1;
                end
                m_cnt[i] = c;
            end
            if (xfer) m_ptr = (g + 1) % CH;
            m_pulse = new_pulse;
        end
        m_select();
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("model pulse_out", pulse_out, m_pulse);
            check("model p_srdy", p_srdy, m_srdy);
            check("model p_chan", p_chan, m_chan);
`ifdef SD_EVENT_SYNC_OVF_EN
            check("model ovf", ovf, m_ovf);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq [3] = '{0, 1, 3};
    int n_xfer;

    initial begin
        reset  = 1'b1;
        tgl_in = '1;
        p_drdy = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst pulse_out", pulse_out, 0);
        check("rst p_srdy", p_srdy, 0);
        check("rst p_chan", p_chan, 0);
        repeat (3) tick();
        @(negedge clk);
        check("post-rst pulse_out", pulse_out, 0);
        check("post-rst p_srdy", p_srdy, 0);
        tick();

        // Single toggle on ch2: strobe two cycles after the sampling edge.
        tgl_in[2] = ~tgl_in[2];
        tick();
        @(negedge clk);
        check("ch2 early pulse", pulse_out, 0);
        tick();
        @(negedge clk);
        check("ch2 pulse", pulse_out, 4'b0100);
        check("ch2 srdy lag", p_srdy, 0);
        tick();
        @(negedge clk);
        check("ch2 pulse width", pulse_out, 0);
        check("ch2 srdy", p_srdy, 1);
        check("ch2 chan", p_chan, 2);
        p_drdy = 1'b1;
        tick();
        p_drdy = 1'b0;
        @(negedge clk);
        check("ch2 drained", p_srdy, 0);
        check("ch2 ptr", p_chan, 3);
        tick();

        // Burst of 5 events on ch1.
        for (int t = 0; t < 5; t++) begin
            tgl_in[1] = ~tgl_in[1];
            tick();
        end
        repeat (4) tick();
        p_drdy = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("ch1 burst srdy", p_srdy, 1);
            check("ch1 burst chan", p_chan, 1);
            tick();
        end
        p_drdy = 1'b0;
        @(negedge clk);
        check("ch1 burst drained", p_srdy, 0);
        tick();

        // Move the pointer back to 0 via one ch3 transfer.
        tgl_in[3] = ~tgl_in[3];
        repeat (4) tick();
        p_drdy = 1'b1;
        @(negedge clk);
        check("ch3 chan", p_chan, 3);
        tick();
        p_drdy = 1'b0;

        // ch0, ch1, ch3 one event each: order 0,1,3.
        tgl_in[0] = ~tgl_in[0];
        tgl_in[1] = ~tgl_in[1];
        tgl_in[3] = ~tgl_in[3];
        repeat (4) tick();
        p_drdy = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("rr srdy", p_srdy, 1);
            check("rr chan", p_chan, seq[t]);
            tick();
        end
        p_drdy = 1'b0;
        @(negedge clk);
        check("rr drained", p_srdy, 0);
        tick();

        // Saturation: 17 events on ch0 leave MAXC pending.
        for (int t = 0; t < MAXC + 2; t++) begin
            tgl_in[0] = ~tgl_in[0];
            tick();
        end
        repeat (4) tick();
`ifdef SD_EVENT_SYNC_OVF_EN
        check("sat ovf", ovf, 4'b0001);
`endif
        p_drdy = 1'b1;
        n_xfer = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!p_srdy) break;
            check("sat chan", p_chan, 0);
            n_xfer++;
            @(posedge clk);
            #1;
        end
        p_drdy = 1'b0;
        check("sat transfers", n_xfer, MAXC);
        tick();

        // Event arriving while ch0 is granted and accepted at count 1.
        tgl_in[0] = ~tgl_in[0];
        repeat (4) tick();
        @(negedge clk);
        check("coll pre srdy", p_srdy, 1);
        check("coll pre chan", p_chan, 0);
        tick();
        tgl_in[0] = ~tgl_in[0];
        tick();
        tick();
        p_drdy = 1'b1;
        @(negedge clk);
        check("coll pulse", pulse_out, 4'b0001);
        tick();
        p_drdy = 1'b0;
        @(negedge clk);
        check("coll srdy held", p_srdy, 1);
        check("coll chan", p_chan, 0);
        p_drdy = 1'b1;
        tick();
        p_drdy = 1'b0;
        @(negedge clk);
        check("coll drained", p_srdy, 0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
